fp32_add_seq: RTL and testbench
===============================

FP32_ADD_SEQ -- requirements
Module: fp32_add_seq

Interface
Parameters: none.
REQ-001 clock  in  1  Single clock; all state updates on rising edge.
REQ-002 reset  in  1  Asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-003 io_in_valid  in  1  Operand pair A/B valid.
REQ-004 io_in_ready  out  1  Block can accept an operand pair; high only in IDLE.
REQ-005 io_fpnumA  in  32  IEEE-754 binary32 operand A, sampled at accept.
REQ-006 io_fpnumB  in  32  IEEE-754 binary32 operand B, sampled at accept.
REQ-007 io_out_valid  out  1  io_fpSum valid; high only in DONE.
REQ-008 io_out_ready  in  1  Consumer accepts io_fpSum.
REQ-009 io_fpSum  out  32  Registered binary32 sum A+B.
REQ-010 io_busy  out  1  High whenever state != IDLE.

Function
REQ-011 The block SHALL be a non-pipelined multi-cycle FSM with states IDLE, UNPACK, ALIGN, ADD, NORM, DONE, holding one operation at a time.
REQ-012 IDLE: accept when io_in_valid & io_in_ready; capture A, B; next state UNPACK. No accept otherwise.
REQ-013 UNPACK (1 cycle): if either exponent == 255, set io_fpSum = 0x7FC00000 and go to DONE; else continue with the steps below.
REQ-014 UNPACK: an operand with exponent 0 SHALL be treated as zero (significand 0, denormals flushed); otherwise significand = {1, mantissa} (24 bits).
REQ-015 UNPACK: order operands so X has larger-or-equal magnitude (compare {exp,mantissa}); d = eX - eY; if d >= 24, clear Y significand and set d = 0; next state ALIGN.
REQ-016 ALIGN: while d != 0, shift Y right 1 bit per cycle, discard shifted-out bits, and decrement d; when d == 0, go to ADD. ALIGN occupies d+1 cycles.
REQ-017 ADD (1 cycle): signs equal -> S = X + Y; signs differ -> S = X - Y (never negative). S is 25 bits; result sign = sign of X; exponent = eX; next state NORM.
REQ-018 NORM, priority order, one action per cycle:
- S == 0 -> result 0x00000000 (+0, including exact cancellation), go to DONE.
- S[24] = 1 -> S >>= 1, exp += 1.
- S[23] = 0 -> S <<= 1, exp -= 1.
- Else pack {sign, exp[7:0], S[22:0]}, go to DONE.
REQ-019 Overflow: exp reaching 255 in NORM SHALL pack {sign, 0x7F800000[30:0]} (signed infinity) and go to DONE.
REQ-020 Underflow: exp reaching 0 with S[23] = 0 SHALL pack {sign, 31'b0} and go to DONE.
REQ-021 Rounding SHALL be truncation (round toward zero); no guard or sticky bits.
REQ-022 Latency: with n = number of NORM shift cycles, io_out_valid SHALL first be high d+n+5 cycles after the accept edge. NaN/Inf shortcut: 2 cycles.
REQ-023 DONE: io_out_valid = 1; io_fpSum stable until handshake. On io_out_ready = 1, go to IDLE next edge. io_in_ready SHALL stay 0 in DONE, so there is no same-cycle re-accept.
REQ-024 io_fpSum SHALL change only on entry to DONE or on reset.

Reset
REQ-025 While reset = 0: state = IDLE, io_fpSum = 0, io_out_valid = 0, io_busy = 0, io_in_ready = 1, and all internal registers cleared.
REQ-026 Reset asserted in any state SHALL abandon the operation in flight with no output handshake; after release, the block SHALL accept from IDLE on the next edge.

Verification
REQ-027 0x3F800000 + 0x3F800000 -> io_fpSum = 0x40000000; io_out_valid 6 cycles after accept.
REQ-028 0x3F800000 + 0xBF800000 -> 0x00000000 at 5 cycles; 0x3FC00000 + 0x3E800000 -> 0x3FE00000 at 7 cycles.
REQ-029 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; 0x7F800000 + 0x3F800000 -> 0x7FC00000 at 2 cycles; 0x3F800000 + 0x30800000 (d = 30) -> 0x3F800000.
REQ-030 Backpressure: hold io_out_ready = 0 for 10 cycles in DONE -> io_fpSum constant, io_in_ready = 0, io_busy = 1. Then io_out_ready = 1 -> IDLE next cycle with io_in_ready = 1.
REQ-031 Assert reset mid-ALIGN (A = 0x3F800000, B = 0x3E800000) -> immediately io_out_valid = 0, io_fpSum = 0, io_in_ready = 1. After release, a new pair SHALL be accepted and produce the correct sum.
REQ-032 Hold io_in_valid = 1 through a complete operation -> exactly one accept per IDLE visit; no operand captured while io_busy = 1.

Source files
------------

// File: rtl/fp32_add_seq.sv
// fp32_add_seq: multi-cycle IEEE-754 binary32 adder, one operation in flight.
// Denormal inputs are flushed to zero, rounding truncates, and any NaN/Inf
// operand yields the canonical quiet NaN.
module fp32_add_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_fpnumA,
    input  logic [31:0] io_fpnumB,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_fpSum,
    output logic        io_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } stateT;

    stateT       stateQ, stateD;
    logic [31:0] opAQ, opAD;
    logic [31:0] opBQ, opBD;
    logic [23:0] sigXQ, sigXD;
    logic [23:0] sigYQ, sigYD;
    logic [7:0]  expQ, expD;
    logic        signQ, signD;
    logic        subQ, subD;
    logic [4:0]  shiftQ, shiftD;
    logic [24:0] sumQ, sumD;
    logic [31:0] fpSumQ, fpSumD;

    // Unpacked views of the captured operands
    logic [7:0]  expA, expB, expY, expDiff;
    logic [23:0] sigA, sigB;
    logic        aGeB;

    assign expA    = opAQ[30:23];
    assign expB    = opBQ[30:23];
    assign sigA    = (expA == 8'd0) ? 24'd0 : {1'b1, opAQ[22:0]};
    assign sigB    = (expB == 8'd0) ? 24'd0 : {1'b1, opBQ[22:0]};
    // Magnitude order on {exp, mantissa}; ties keep A as the larger operand
    assign aGeB    = (opAQ[30:0] >= opBQ[30:0]);
    assign expY    = aGeB ? expB : expA;
    assign expDiff = (aGeB ? expA : expB) - expY;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
            opAQ   <= 32'd0;
            opBQ   <= 32'd0;
            sigXQ  <= 24'd0;
            sigYQ  <= 24'd0;
            expQ   <= 8'd0;
            signQ  <= 1'b0;
            subQ   <= 1'b0;
            shiftQ <= 5'd0;
            sumQ   <= 25'd0;
            fpSumQ <= 32'd0;
        end else begin
            stateQ <= stateD;
            opAQ   <= opAD;
            opBQ   <= opBD;
            sigXQ  <= sigXD;
            sigYQ  <= sigYD;
            expQ   <= expD;
            signQ  <= signD;
            subQ   <= subD;
            shiftQ <= shiftD;
            sumQ   <= sumD;
            fpSumQ <= fpSumD;
        end
    end

    // Next-state and datapath update for each phase of the operation
    always_comb begin
        stateD = stateQ;
        opAD   = opAQ;
        opBD   = opBQ;
        sigXD  = sigXQ;
        sigYD  = sigYQ;
        expD   = expQ;
        signD  = signQ;
        subD   = subQ;
        shiftD = shiftQ;
        sumD   = sumQ;
        fpSumD = fpSumQ;

        unique case (stateQ)
            StIdle: begin
                if (io_in_valid) begin
                    opAD   = io_fpnumA;
                    opBD   = io_fpnumB;
                    stateD = StUnpack;
                end
            end

            StUnpack: begin
                if (expA == 8'hFF || expB == 8'hFF) begin
                    fpSumD = 32'h7FC0_0000;
                    stateD = StDone;
                end else begin
                    sigXD  = aGeB ? sigA : sigB;
                    expD   = aGeB ? expA : expB;
                    signD  = aGeB ? opAQ[31] : opBQ[31];
                    subD   = opAQ[31] ^ opBQ[31];
                    // Anything shifted 24 or more places vanishes entirely
                    if (expDiff >= 8'd24) begin
                        sigYD  = 24'd0;
                        shiftD = 5'd0;
                    end else begin
                        sigYD  = aGeB ? sigB : sigA;
                        shiftD = expDiff[4:0];
                    end
                    stateD = StAlign;
                end
            end

            StAlign: begin
                if (shiftQ != 5'd0) begin
                    sigYD  = sigYQ >> 1;
                    shiftD = shiftQ - 5'd1;
                end else begin
                    stateD = StAdd;
                end
            end

            StAdd: begin
                // X >= Y in magnitude, so the difference never goes negative
                sumD   = subQ ? ({1'b0, sigXQ} - {1'b0, sigYQ})
                              : ({1'b0, sigXQ} + {1'b0, sigYQ});
                stateD = StNorm;
            end

            StNorm: begin
                if (sumQ == 25'd0) begin
                    fpSumD = 32'h0000_0000;
                    stateD = StDone;
                end else if (sumQ[24]) begin
                    if (expQ == 8'd254) begin
                        fpSumD = {signQ, 31'h7F80_0000};
                        stateD = StDone;
                    end else begin
                        sumD = sumQ >> 1;
                        expD = expQ + 8'd1;
                    end
                end else if (!sumQ[23]) begin
                    // A further left shift would reach exponent 0: flush to zero
                    if (expQ <= 8'd1) begin
                        fpSumD = {signQ, 31'd0};
                        stateD = StDone;
                    end else begin
                        sumD = sumQ << 1;
                        expD = expQ - 8'd1;
                    end
                end else begin
                    fpSumD = {signQ, expQ, sumQ[22:0]};
                    stateD = StDone;
                end
            end

            StDone: begin
                if (io_out_ready) begin
                    stateD = StIdle;
                end
            end

            default: stateD = StIdle;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        io_in_ready  = (stateQ == StIdle);
        io_out_valid = (stateQ == StDone);
        io_busy      = (stateQ != StIdle);
        io_fpSum     = fpSumQ;
    end

endmodule

// File: tb/tb_fp32_add_seq.sv
// tb_fp32_add_seq: directed vectors with hand-computed sums and latencies.
module tb_fp32_add_seq;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_fpnumA;
    logic [31:0] io_fpnumB;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_fpSum;
    logic        io_busy;

    int passed = 0;
    int total  = 0;
    int accepts = 0;

    fp32_add_seq dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_fpnumA   (io_fpnumA),
        .io_fpnumB   (io_fpnumB),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_fpSum    (io_fpSum),
        .io_busy     (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count handshakes seen on the input side
    always @(posedge clock) begin
        if (reset && io_in_valid && io_in_ready) accepts++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called just after the accept edge; counts that edge as 1
    task automatic waitDone(output int lat);
        lat = 1;
        while (!io_out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        check({tag, " ready after handshake"}, {31'd0, io_in_ready}, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expSum, input int expLat);
        int lat;
        check({tag, " in_ready before accept"}, {31'd0, io_in_ready}, 32'd1);
        io_fpnumA   = a;
        io_fpnumB   = b;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        waitDone(lat);
        check({tag, " sum"}, io_fpSum, expSum);
        check({tag, " latency"}, lat, expLat);
        handshake(tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        io_fpnumA    = 32'd0;
        io_fpnumB    = 32'd0;
        #2;
        check("reset in_ready", {31'd0, io_in_ready}, 32'd1);
        check("reset out_valid", {31'd0, io_out_valid}, 32'd0);
        check("reset busy", {31'd0, io_busy}, 32'd0);
        check("reset sum", io_fpSum, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        runOp("1+1", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 6);
        runOp("1-1", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 5);
        runOp("1.5+0.25", 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 7);
        runOp("max+max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 5);
        runOp("inf+1", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2);
        runOp("1+tiny", 32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 5);
        runOp("1-0.25", 32'h3F80_0000, 32'hBE80_0000, 32'h3F40_0000, 8);
        runOp("-1+0.25", 32'h3E80_0000, 32'hBF80_0000, 32'hBF40_0000, 8);
        runOp("denorm+1", 32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000, 5);

        // Backpressure: result and status hold while the consumer stalls
        io_fpnumA   = 32'h3FC0_0000;
        io_fpnumB   = 32'h3E80_0000;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        waitDone(lat);
        check("bp sum", io_fpSum, 32'h3FE0_0000);
        held = io_fpSum;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("bp sum held", io_fpSum, held);
            check("bp in_ready low", {31'd0, io_in_ready}, 32'd0);
            check("bp busy", {31'd0, io_busy}, 32'd1);
        end
        handshake("bp");

        // Reset in the middle of ALIGN abandons the operation
        io_fpnumA   = 32'h3F80_0000;
        io_fpnumB   = 32'h3E80_0000;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("mid busy", {31'd0, io_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst out_valid", {31'd0, io_out_valid}, 32'd0);
        check("rst sum", io_fpSum, 32'd0);
        check("rst in_ready", {31'd0, io_in_ready}, 32'd1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        runOp("post-rst", 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 7);

        // Valid held high: one accept per IDLE visit, operands ignored while busy
        accepts     = 0;
        io_fpnumA   = 32'h3F80_0000;
        io_fpnumB   = 32'h3F80_0000;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_fpnumA = 32'h4000_0000;
        waitDone(lat);
        check("hold sum1", io_fpSum, 32'h4000_0000);
        check("hold lat1", lat, 6);
        check("hold accepts1", accepts, 1);
        handshake("hold");
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        waitDone(lat);
        check("hold sum2", io_fpSum, 32'h4040_0000);
        check("hold lat2", lat, 6);
        check("hold accepts2", accepts, 2);
        handshake("hold2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
